timer_apb_sequencer: RTL and testbench

APB3 master that owns one CoreTimer instance (WIDTH=32, interrupt active-high) and sequences it without processor involvement. A start pulse runs the configure sequence: disable, prescale, load, clear interrupt, enable. While the timer runs, the block services each TIMINT with an interrupt-clear write and emits a tick pulse, and supports on-demand snapshots of the current count and a stop command. It sits between fabric control logic and the timer's APB slave port.

---
 rtl/timer_apb_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_timer_apb_sequencer.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/timer_apb_sequencer.sv
// APB3 master that configures a CoreTimer, services its interrupt with IntClr
// writes, takes on-demand Value snapshots and disables the timer on request.
module timer_apb_sequencer #(
  parameter int unsigned TICK_W = 16,
  parameter int unsigned GUARD  = 2
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              cfg_start,
  input  logic              cfg_stop,
  input  logic [31:0]       cfg_load,
  input  logic [3:0]        cfg_prescale,
  input  logic              cfg_oneshot,
  input  logic              snap_req,
  input  logic              TIMINT,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [2:0]        PADDR,
  output logic [31:0]       PWDATA,
  input  logic [31:0]       PRDATA,
  output logic              busy,
  output logic              running,
  output logic              tick,
  output logic [TICK_W-1:0] tick_count,
  output logic [31:0]       value_out,
  output logic              value_valid
);

  localparam int unsigned GCW = (GUARD > 1) ? $clog2(GUARD) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_CFG, S_RUN, S_SVC, S_GUARD, S_SNAP, S_HALT
  } state_t;

  state_t            state_q, state_d;
  logic              access_q, access_d;
  logic [2:0]        step_q, step_d;
  logic [GCW-1:0]    gcnt_q, gcnt_d;
  logic [31:0]       load_q, load_d;
  logic [3:0]        pre_q, pre_d;
  logic              os_q, os_d;
  logic              stop_q, stop_d;
  logic              snap_q, snap_d;
  logic [TICK_W-1:0] tcnt_q, tcnt_d;
  logic [31:0]       value_q, value_d;
  logic              vvalid_q, vvalid_d;
  logic              xfer, stop_now;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q  <= S_IDLE;
      access_q <= 1'b0;
      step_q   <= '0;
      gcnt_q   <= '0;
      load_q   <= '0;
      pre_q    <= '0;
      os_q     <= 1'b0;
      stop_q   <= 1'b0;
      snap_q   <= 1'b0;
      tcnt_q   <= '0;
      value_q  <= '0;
      vvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      access_q <= access_d;
      step_q   <= step_d;
      gcnt_q   <= gcnt_d;
      load_q   <= load_d;
      pre_q    <= pre_d;
      os_q     <= os_d;
      stop_q   <= stop_d;
      snap_q   <= snap_d;
      tcnt_q   <= tcnt_d;
      value_q  <= value_d;
      vvalid_q <= vvalid_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    gcnt_d   = gcnt_q;
    load_d   = load_q;
    pre_d    = pre_q;
    os_d     = os_q;
    stop_d   = stop_q;
    snap_d   = snap_q;
    tcnt_d   = tcnt_q;
    value_d  = value_q;
    vvalid_d = 1'b0;
    xfer     = (state_q == S_CFG) || (state_q == S_SVC) ||
               (state_q == S_SNAP) || (state_q == S_HALT);
    // Every transfer state alternates SETUP/ACCESS and always leaves on ACCESS,
    // so the phase bit naturally returns to SETUP for the next transfer.
    access_d = xfer && !access_q;
    stop_now = stop_q || cfg_stop;

    if (cfg_stop && state_q != S_IDLE && state_q != S_HALT) stop_d = 1'b1;
    if (snap_req && (state_q == S_RUN || state_q == S_SVC ||
                     state_q == S_GUARD || state_q == S_SNAP)) snap_d = 1'b1;

    case (state_q)
      S_IDLE: if (cfg_start) begin
        load_d  = cfg_load;
        pre_d   = cfg_prescale;
        os_d    = cfg_oneshot;
        tcnt_d  = '0;
        step_d  = '0;
        stop_d  = 1'b0;
        snap_d  = 1'b0;
        state_d = S_CFG;
      end
      S_CFG: if (access_q) begin
        if (step_q == 3'd4) state_d = stop_now ? S_HALT : S_RUN;
        else                step_d  = step_q + 3'd1;
      end
      S_RUN: begin
        if (stop_now) begin
          state_d = S_HALT;
        end else if (TIMINT) begin
          state_d = S_SVC;
        end else if (snap_q || snap_req) begin
          snap_d  = 1'b0;
          state_d = S_SNAP;
        end
      end
      S_SVC: if (access_q) begin
        tcnt_d  = tcnt_q + TICK_W'(1);
        gcnt_d  = GCW'(GUARD - 1);
        state_d = stop_now ? S_HALT : S_GUARD;
      end
      S_GUARD: begin
        if (gcnt_q == '0) state_d = (stop_now || os_q) ? S_HALT : S_RUN;
        else              gcnt_d  = gcnt_q - GCW'(1);
      end
      S_SNAP: if (access_q) begin
        value_d  = PRDATA;
        vvalid_d = 1'b1;
        state_d  = stop_now ? S_HALT : S_RUN;
      end
      S_HALT: begin
        snap_d = 1'b0;
        if (access_q) begin
          stop_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    PADDR  = '0;
    PWDATA = '0;
    case (state_q)
      S_CFG: begin
        case (step_q)
          3'd0:    PADDR = 3'd2;
          3'd1:    begin PADDR = 3'd3; PWDATA = {28'b0, pre_q}; end
          3'd2:    begin PADDR = 3'd0; PWDATA = load_q; end
          3'd3:    PADDR = 3'd4;
          default: begin PADDR = 3'd2; PWDATA = {29'b0, os_q, 2'b11}; end
        endcase
      end
      S_SVC:   PADDR = 3'd4;
      S_SNAP:  PADDR = 3'd1;
      S_HALT:  PADDR = 3'd2;
      default: PADDR = '0;
    endcase
  end

  assign PSEL        = xfer;
  assign PENABLE     = xfer && access_q;
  assign PWRITE      = xfer && (state_q != S_SNAP);
  assign busy        = (state_q != S_IDLE);
  assign running     = (state_q == S_RUN) || (state_q == S_SVC) || (state_q == S_GUARD) ||
                       (state_q == S_SNAP) || (state_q == S_HALT);
  assign tick        = (state_q == S_SVC) && access_q;
  assign tick_count  = tcnt_q;
  assign value_out   = value_q;
  assign value_valid = vvalid_q;

endmodule

// File: tb/tb_timer_apb_sequencer.sv
// Directed bench for timer_apb_sequencer: configure, interrupt service, snapshot,
// stop, one-shot and mid-transfer reset, with hand-computed expectations.
module tb_timer_apb_sequencer;

  logic        PCLK = 1'b0;
  logic        PRESET = 1'b1;
  logic        cfg_start = 1'b0, cfg_stop = 1'b0, cfg_oneshot = 1'b0;
  logic [31:0] cfg_load = '0;
  logic [3:0]  cfg_prescale = '0;
  logic        snap_req = 1'b0, TIMINT = 1'b0;
  logic        PSEL, PENABLE, PWRITE;
  logic [2:0]  PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA = '0;
  logic        busy, running, tick, value_valid;
  logic [15:0] tick_count;
  logic [31:0] value_out;

  int n_checks = 0;
  int n_pass   = 0;
  int ticks_seen = 0;

  timer_apb_sequencer #(.TICK_W(16), .GUARD(2)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .cfg_start(cfg_start), .cfg_stop(cfg_stop),
    .cfg_load(cfg_load), .cfg_prescale(cfg_prescale), .cfg_oneshot(cfg_oneshot),
    .snap_req(snap_req), .TIMINT(TIMINT), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
    .busy(busy), .running(running), .tick(tick), .tick_count(tick_count),
    .value_out(value_out), .value_valid(value_valid)
  );

  always #5 PCLK = ~PCLK;

  always @(posedge PCLK) if (tick) ticks_seen <= ticks_seen + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge PCLK);
    #1;
  endtask

  // Waits (bounded) for SETUP, checks it, advances into ACCESS and checks it.
  // Leaves the bench sitting in the ACCESS cycle.
  task automatic expect_xfer(input string tag, input logic [2:0] a,
                             input logic [31:0] d, input logic wr);
    int n = 0;
    while (!(PSEL && !PENABLE) && n < 8) begin
      step();
      n++;
    end
    check({tag, " setup ctl"}, {29'b0, PSEL, PENABLE, PWRITE}, {29'b0, 1'b1, 1'b0, wr});
    check({tag, " setup addr"}, {29'b0, PADDR}, {29'b0, a});
    if (wr) check({tag, " setup data"}, PWDATA, d);
    step();
    check({tag, " access ctl"}, {29'b0, PSEL, PENABLE, PWRITE}, {29'b0, 1'b1, 1'b1, wr});
    check({tag, " access addr"}, {29'b0, PADDR}, {29'b0, a});
    if (wr) check({tag, " access data"}, PWDATA, d);
  endtask

  task automatic start(input logic [31:0] ld, input logic [3:0] pre, input logic os);
    cfg_load = ld; cfg_prescale = pre; cfg_oneshot = os; cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
  endtask

  task automatic cfg_seq(input string tag, input logic [31:0] ld, input logic [3:0] pre,
                         input logic os);
    check({tag, " first setup"}, {31'b0, PSEL}, 32'd1);
    expect_xfer({tag, " ctl0"}, 3'd2, 32'd0, 1'b1); step();
    expect_xfer({tag, " pre"}, 3'd3, {28'b0, pre}, 1'b1); step();
    expect_xfer({tag, " load"}, 3'd0, ld, 1'b1); step();
    expect_xfer({tag, " iclr"}, 3'd4, 32'd0, 1'b1); step();
    expect_xfer({tag, " en"}, 3'd2, {29'b0, os, 2'b11}, 1'b1); step();
    check({tag, " running"}, {30'b0, running, busy}, 32'd3);
  endtask

  // Services one interrupt; TIMINT lingers into the first GUARD cycle.
  task automatic service(input string tag);
    TIMINT = 1'b1;
    step();
    expect_xfer({tag, " iclr"}, 3'd4, 32'd0, 1'b1);
    check({tag, " tick"}, {31'b0, tick}, 32'd1);
    step();
    step();
    TIMINT = 1'b0;
    step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    step(); step();
    PRESET = 1'b0;
    check("reset bus", {27'b0, PSEL, PENABLE, PWRITE, busy, running}, 32'd0);
    check("reset addr/data", {29'b0, PADDR} | PWDATA, 32'd0);
    check("reset tick", {15'b0, tick, tick_count}, 32'd0);
    check("reset value", value_out | {31'b0, value_valid}, 32'd0);

    // Periodic configure.
    start(32'd100, 4'd0, 1'b0);
    cfg_seq("per", 32'd100, 4'd0, 1'b0);
    step();
    check("run idle bus", {31'b0, PSEL}, 32'd0);

    // Three separate interrupts, no double counting while TIMINT lingers.
    ticks_seen = 0;
    service("int1");
    check("int1 back to run", {30'b0, PSEL, running}, 32'd1);
    service("int2");
    step();
    service("int3");
    step(); step();
    check("tick_count 3", {16'b0, tick_count}, 32'd3);
    check("ticks seen 3", ticks_seen, 32'd3);
    check("no extra xfer", {31'b0, PSEL}, 32'd0);

    // Snapshot.
    PRDATA = 32'h1234_5678;
    snap_req = 1'b1;
    step();
    snap_req = 1'b0;
    expect_xfer("snap", 3'd1, 32'd0, 1'b0);
    step();
    check("snap valid", {31'b0, value_valid}, 32'd1);
    check("snap value", value_out, 32'h1234_5678);
    step();
    check("snap valid drop", {31'b0, value_valid}, 32'd0);
    PRDATA = '0;

    // Stop and TIMINT together: stop wins, no tick.
    ticks_seen = 0;
    cfg_stop = 1'b1; TIMINT = 1'b1;
    step();
    cfg_stop = 1'b0; TIMINT = 1'b0;
    expect_xfer("halt", 3'd2, 32'd0, 1'b1);
    check("halt running", {30'b0, running, busy}, 32'd3);
    step();
    check("halt idle", {30'b0, running, busy}, 32'd0);
    check("halt no tick", ticks_seen, 32'd0);
    check("halt count kept", {16'b0, tick_count}, 32'd3);

    // One-shot: one interrupt, then self-disable.
    start(32'd50, 4'd5, 1'b1);
    check("os count clear", {16'b0, tick_count}, 32'd0);
    cfg_seq("os", 32'd50, 4'd5, 1'b1);
    service("os int");
    expect_xfer("os halt", 3'd2, 32'd0, 1'b1);
    step();
    check("os idle", {31'b0, busy}, 32'd0);
    check("os count", {16'b0, tick_count}, 32'd1);

    // Reset during ACCESS of the Load write.
    start(32'd77, 4'd2, 1'b0);
    expect_xfer("rst ctl0", 3'd2, 32'd0, 1'b1); step();
    expect_xfer("rst pre", 3'd3, 32'd2, 1'b1); step();
    expect_xfer("rst load", 3'd0, 32'd77, 1'b1);
    PRESET = 1'b1;
    #1;
    check("async rst bus", {29'b0, PSEL, PENABLE, busy}, 32'd0);
    check("async rst addr/data", {29'b0, PADDR} | PWDATA, 32'd0);
    step();
    PRESET = 1'b0;
    step();
    start(32'd200, 4'd1, 1'b0);
    cfg_seq("restart", 32'd200, 4'd1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
